partial_state_injector: RTL and testbench
=========================================

# partial_state_injector

Drives the lifted terminals of an extracted partial circuit: the lifted inputs and register-next-state (`*_in`) ports. It reads them back through a captured snapshot of the partial's outputs. Stimulus arrives as a serial bit stream, collects in a shadow register, and commits atomically to a parallel output bus with one apply pulse. A capture path snapshots a parallel bus and serializes it back out. The block is the writer/reader counterpart that a bench or on-chip harness places in front of any `_*_Partial` module.

## Interface
- `WIDTH`, default 8: number of lifted terminal bits driven and captured. Must be ≥ 2.
- `INIT`, default 0: reset value of `lifted_out`, WIDTH bits.
- `CLK` in, 1: the single clock. All state changes on the rising edge.
- `ASYNCRESET` in, 1: asynchronous, active-high reset.
- `sin_valid` in, 1: serial load bit is valid.
- `sin_data` in, 1: serial load bit, LSB of the target word first.
- `sin_ready` out, 1: block accepts a load bit this cycle.
- `apply` in, 1: single-cycle pulse that commits the shadow word to `lifted_out`.
- `abort` in, 1: discards a partial or full load.
- `lifted_out` out, WIDTH: parallel value that drives the partial's lifted inputs.
- `capture` in, 1: single-cycle pulse that snapshots `capture_in`.
- `capture_in` in, WIDTH: parallel outputs of the partial circuit.
- `sout_valid` out, 1: serial readback bit is valid.
- `sout_data` out, 1: readback bit, LSB first.
- `sout_ready` in, 1: consumer accepts the readback bit.
- `busy` out, 1: high whenever the state is not IDLE.

## Operation
- **State machine.** States are IDLE, LOAD, FULL and DRAIN. Registers are `shadow[WIDTH]`, `rdbk[WIDTH]` and `cnt` (clog2(WIDTH+1) bits).
- **`sin_ready`.** High in IDLE and LOAD; low in FULL and DRAIN.
- **Load beat.** A beat is `sin_valid & sin_ready`. On each beat: `shadow <= {sin_data, shadow[WIDTH-1:1]}` and `cnt <= cnt+1`.
- **Load transitions.**
  - IDLE goes to LOAD on the first beat.
  - LOAD goes to FULL on the beat that makes `cnt == WIDTH`.
- **Apply.**
  - In FULL, `apply` sets `lifted_out <= shadow`, `cnt <= 0`, and returns to IDLE.
  - `apply` in any other state is ignored; `lifted_out` is unchanged.
- **Abort.**
  - In LOAD or FULL, `abort` sets `cnt <= 0` and returns to IDLE.
  - `lifted_out` is unchanged and `shadow` keeps its contents.
  - `abort` has priority over both a load beat and `apply` in the same cycle.
- **Capture.**
  - In IDLE, `capture` sets `rdbk <= capture_in`, `cnt <= 0`, and goes to DRAIN.
  - If `capture` and a load beat occur in the same IDLE cycle, the load beat wins and `capture` is dropped.
  - `capture` outside IDLE is ignored.
- **DRAIN.**
  - `sout_valid = 1` and `sout_data = rdbk[0]`.
  - On `sout_valid & sout_ready`: `rdbk <= rdbk >> 1` and `cnt <= cnt+1`.
  - On the handshake with `cnt == WIDTH-1`, return to IDLE with `cnt <= 0`.
- **Abort in DRAIN.** `abort` in DRAIN returns to IDLE; `sout_valid` drops the next cycle.
- **Output gating.** `sout_valid = 0` outside DRAIN; `sout_data = 0` when not valid.
- **Wrap-around.** `cnt` never exceeds WIDTH; no beat is accepted once FULL.

## Timing
- **Reset values (all asynchronous on `ASYNCRESET`):**
  - state = IDLE
  - `lifted_out` = INIT
  - `shadow` = 0, `rdbk` = 0, `cnt` = 0
  - `sin_ready` = 1, `sout_valid` = 0, `sout_data` = 0, `busy` = 0
- **Reset mid-operation.** Reset during LOAD, FULL or DRAIN discards all progress. `lifted_out` returns to INIT.
- **Load latency.** A full load takes WIDTH accepted beats. Minimum beat-to-beat spacing is one cycle.
- **Commit latency.** `lifted_out` changes on the edge that samples `apply`, so the new value is visible the cycle after `apply`.
  - Minimum time from first beat to a new `lifted_out` is WIDTH+1 cycles.
- **Output stability.** `lifted_out` is registered and never changes except on an apply or reset; it has no glitches during loading.
- **Readback timing.**
  - `sout_valid` rises the cycle after `capture`.
  - `capture_in` is sampled only on the `capture` edge.
  - Readback needs WIDTH accepted handshakes; backpressure via `sout_ready` stalls with `sout_data` held.
- **Signal classes.** `sin_ready`, `sout_valid`, `sout_data` and `busy` are decoded from registered state only (no input-to-output combinational paths).

## Test plan
All scenarios use WIDTH=4.
- **Reset.** Assert `ASYNCRESET` between edges → `lifted_out`=INIT immediately, `busy`=0, `sin_ready`=1, `sout_valid`=0.
- **Load and apply.** Beats 1,0,1,1 → FULL with `sin_ready`=0. Pulse `apply` → `lifted_out`=4'hD next cycle and `busy`=0.
- **Gapped load.** Same four beats with `sin_valid` low for 3 cycles between beats → identical result.
  - An extra beat offered in FULL is not accepted.
- **Abort and ignored apply.**
  - Apply 4'hD.
  - Send two beats, then `abort` → IDLE with `lifted_out` still 4'hD.
  - `apply` in IDLE → no change.
  - Abort together with the fourth beat → IDLE, not FULL.
- **Capture readback.** `capture_in`=4'b0110 with `capture` → `sout_data` sequence 0,1,1,0.
  - Hold `sout_ready` low 2 cycles mid-stream → bit held.
  - Back to IDLE after the 4th handshake.
- **Priority and reset mid-stream.**
  - In IDLE, assert `capture` with a load beat → LOAD entered and `sout_valid` stays 0.
  - `ASYNCRESET` mid-DRAIN → `sout_valid`=0 and `lifted_out`=INIT.

Source files
------------

// File: rtl/partial_state_injector.sv
// partial_state_injector
//   Writer/reader harness for an extracted partial circuit. A serial bit
//   stream (LSB first) is collected into a shadow register. An apply pulse
//   then commits it atomically to the parallel lifted_out bus. A capture
//   pulse snapshots capture_in, which is then shifted back out serially with
//   a valid/ready handshake.
// Ports:
//   CLK, ASYNCRESET             clock, async active-high reset
//   sin_valid/sin_data/sin_ready serial load stream
//   apply, abort                commit shadow word / discard load or readback
//   lifted_out[WIDTH]           registered drive for the partial's lifted inputs
//   capture, capture_in[WIDTH]  snapshot strobe and the partial's outputs
//   sout_valid/sout_data/sout_ready serial readback stream
//   busy                        state is not IDLE
module partial_state_injector #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  input  logic             apply,
  input  logic             abort,
  output logic [WIDTH-1:0] lifted_out,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_in,
  output logic             sout_valid,
  output logic             sout_data,
  input  logic             sout_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [WIDTH-1:0] rdbk, rdbk_nxt;
  logic [WIDTH-1:0] lifted_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             beat;

  // All status outputs decode registered state only.
  assign sin_ready  = (state == IDLE) || (state == LOAD);
  assign sout_valid = (state == DRAIN);
  assign sout_data  = (state == DRAIN) ? rdbk[0] : 1'b0;
  assign busy       = (state != IDLE);
  assign beat       = sin_valid & sin_ready;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state      <= IDLE;
      shadow     <= '0;
      rdbk       <= '0;
      cnt        <= '0;
      lifted_out <= INIT;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_nxt;
      rdbk       <= rdbk_nxt;
      cnt        <= cnt_nxt;
      lifted_out <= lifted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    rdbk_nxt   = rdbk;
    cnt_nxt    = cnt;
    lifted_nxt = lifted_out;
    unique case (state)
      IDLE: begin
        // A load beat outranks capture in the same cycle.
        if (beat) begin
          shadow_nxt = {sin_data, shadow[WIDTH-1:1]};
          cnt_nxt    = cnt + CNT_ONE;
          state_nxt  = LOAD;
        end else if (capture) begin
          rdbk_nxt  = capture_in;
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end
      end
      LOAD: begin
        // Abort discards progress; shadow keeps its bits (they are fully
        // overwritten by the next complete load anyway).
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (beat) begin
          shadow_nxt = {sin_data, shadow[WIDTH-1:1]};
          cnt_nxt    = cnt + CNT_ONE;
          if (cnt + CNT_ONE == CNT_FULL) state_nxt = FULL;
        end
      end
      FULL: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (apply) begin
          lifted_nxt = shadow;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end
      end
      DRAIN: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (sout_ready) begin
          rdbk_nxt = rdbk >> 1;
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_partial_state_injector.sv
module tb_partial_state_injector;
  localparam int         W    = 4;
  localparam logic [3:0] INIT = 4'hA;

  logic CLK = 0, ASYNCRESET = 0;
  logic sin_valid = 0, sin_data = 0, apply = 0, abort = 0, capture = 0, sout_ready = 0;
  logic [W-1:0] capture_in = '0;
  logic sin_ready, sout_valid, sout_data, busy;
  logic [W-1:0] lifted_out;

  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  partial_state_injector #(.WIDTH(W), .INIT(INIT)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready),
    .apply(apply), .abort(abort), .lifted_out(lifted_out),
    .capture(capture), .capture_in(capture_in),
    .sout_valid(sout_valid), .sout_data(sout_data), .sout_ready(sout_ready),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    sin_valid = 0; apply = 0; abort = 0; capture = 0; sout_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1 ASYNCRESET = 1;
    #1;
    chk("rst_lifted", lifted_out, INIT);
    chk("rst_busy", busy, 0);
    chk("rst_sin_ready", sin_ready, 1);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_sout_data", sout_data, 0);
    @(negedge CLK);
    ASYNCRESET = 0;
    clr();
    tick();
  endtask

  task automatic beat(input logic b);
    sin_valid = 1; sin_data = b;
    tick();
    sin_valid = 0;
  endtask

  task automatic load_word(input logic [3:0] w, input int gap);
    for (int i = 0; i < W; i++) begin
      beat(w[i]);
      if (i < W - 1) repeat (gap) tick();
    end
  endtask

  typedef struct {
    logic [3:0] word;
    int         gap;
    logic [3:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [3:0] cin;
    int         stall_at;
    logic [3:0] exp_seq;   // exp_seq[i] is the i-th serial bit
  } cap_vec_t;

  // Reference model: load/readback as queues of bits.
  bit         m_load_q[$];
  bit         m_drain_q[$];
  bit         m_draining;
  logic [3:0] m_lifted;

  function automatic logic [3:0] q2word();
    logic [3:0] w = '0;
    for (int i = 0; i < W; i++) w[i] = m_load_q[i];
    return w;
  endfunction

  task automatic model_step();
    if (m_draining) begin
      if (abort) begin
        m_draining = 0; m_drain_q.delete();
      end else if (sout_ready) begin
        void'(m_drain_q.pop_front());
        if (m_drain_q.size() == 0) m_draining = 0;
      end
    end else if (m_load_q.size() == W) begin
      if (abort) m_load_q.delete();
      else if (apply) begin
        m_lifted = q2word();
        m_load_q.delete();
      end
    end else if (m_load_q.size() > 0) begin
      if (abort) m_load_q.delete();
      else if (sin_valid) m_load_q.push_back(sin_data);
    end else begin
      if (sin_valid) m_load_q.push_back(sin_data);
      else if (capture) begin
        for (int i = 0; i < W; i++) m_drain_q.push_back(capture_in[i]);
        m_draining = 1;
      end
    end
  endtask

  initial begin
    ld_vec_t  lv[5];
    cap_vec_t cv[4];
    int       rbad;

    lv[0] = '{4'hD, 0, 4'hD};
    lv[1] = '{4'hD, 3, 4'hD};
    lv[2] = '{4'h0, 1, 4'h0};
    lv[3] = '{4'hF, 0, 4'hF};
    lv[4] = '{4'h6, 2, 4'h6};

    cv[0] = '{4'b0110, 2, 4'b0110};
    cv[1] = '{4'b1001, 0, 4'b1001};
    cv[2] = '{4'b1111, 3, 4'b1111};
    cv[3] = '{4'b0001, 1, 4'b0001};

    do_reset();

    // Load/apply vectors, each followed by an extra beat offered in FULL.
    foreach (lv[k]) begin
      load_word(lv[k].word, lv[k].gap);
      chk("full_sin_ready", sin_ready, 0);
      chk("full_busy", busy, 1);
      beat(~lv[k].word[0]);
      chk("full_no_accept", sin_ready, 0);
      apply = 1; tick(); apply = 0;
      chk("apply_lifted", lifted_out, lv[k].exp);
      chk("apply_busy", busy, 0);
    end

    // Abort and ignored apply.
    load_word(4'hD, 0);
    apply = 1; tick(); apply = 0;
    chk("pre_abort_lifted", lifted_out, 4'hD);
    beat(0); beat(1);
    chk("two_beat_busy", busy, 1);
    abort = 1; tick(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_lifted", lifted_out, 4'hD);
    apply = 1; tick(); apply = 0;
    chk("idle_apply_lifted", lifted_out, 4'hD);
    beat(0); beat(0); beat(0);
    abort = 1; beat(0); abort = 0;
    chk("abort4_busy", busy, 0);
    chk("abort4_sin_ready", sin_ready, 1);
    apply = 1; tick(); apply = 0;
    chk("abort4_lifted", lifted_out, 4'hD);

    // Capture readback vectors with a 2-cycle stall.
    foreach (cv[k]) begin
      capture_in = cv[k].cin; capture = 1; tick(); capture = 0;
      capture_in = ~cv[k].cin;   // must not matter after the capture edge
      for (int i = 0; i < W; i++) begin
        chk("rb_valid", sout_valid, 1);
        chk("rb_data", sout_data, cv[k].exp_seq[i]);
        if (i == cv[k].stall_at) begin
          sout_ready = 0;
          repeat (2) begin
            tick();
            chk("rb_hold", sout_data, cv[k].exp_seq[i]);
          end
        end
        sout_ready = 1; tick(); sout_ready = 0;
      end
      chk("rb_done_busy", busy, 0);
      chk("rb_done_valid", sout_valid, 0);
      chk("rb_done_data", sout_data, 0);
    end

    // Capture together with a load beat: load wins.
    capture_in = 4'hF; capture = 1; beat(1); capture = 0;
    chk("prio_busy", busy, 1);
    chk("prio_sin_ready", sin_ready, 1);
    chk("prio_sout_valid", sout_valid, 0);
    abort = 1; tick(); abort = 0;

    // Abort in DRAIN.
    capture_in = 4'h3; capture = 1; tick(); capture = 0;
    chk("drain_valid", sout_valid, 1);
    abort = 1; tick(); abort = 0;
    chk("drain_abort_valid", sout_valid, 0);
    chk("drain_abort_busy", busy, 0);

    // Reset mid-DRAIN.
    capture_in = 4'h5; capture = 1; tick(); capture = 0;
    sout_ready = 1; tick(); sout_ready = 0;
    chk("mid_drain_valid", sout_valid, 1);
    do_reset();
    chk("post_rst_lifted", lifted_out, INIT);

    // Randomized run against the queue model.
    m_load_q.delete(); m_drain_q.delete(); m_draining = 0; m_lifted = INIT;
    rbad = 0;
    for (int c = 0; c < 3000; c++) begin
      logic exp_sr, exp_sv, exp_sd, exp_busy;
      exp_sv   = m_draining;
      exp_sd   = m_draining ? m_drain_q[0] : 1'b0;
      exp_sr   = !m_draining && (m_load_q.size() < W);
      exp_busy = m_draining || (m_load_q.size() > 0);
      if (rbad < 10) begin
        int b0 = bad;
        chk("rnd_lifted", lifted_out, m_lifted);
        chk("rnd_sin_ready", sin_ready, exp_sr);
        chk("rnd_sout_valid", sout_valid, exp_sv);
        chk("rnd_sout_data", sout_data, exp_sd);
        chk("rnd_busy", busy, exp_busy);
        rbad += bad - b0;
      end
      sin_valid  = ($urandom_range(1) == 1);
      sin_data   = $urandom_range(1);
      apply      = ($urandom_range(2) == 0);
      abort      = ($urandom_range(19) == 0);
      capture    = ($urandom_range(3) == 0);
      sout_ready = ($urandom_range(4) < 3);
      capture_in = 4'($urandom);
      model_step();
      tick();
    end
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
